// File: rtl/param_updown_cnt_pkg.sv
// Shared helpers for the parametrised up/down counter.
// Width helper for the prescaler count register.
package param_updown_cnt_pkg;

   // Bits needed to hold 0..p-1, never less than one.
   function automatic int pw_of(input int p);
      return ($clog2(p) > 0) ? $clog2(p) : 1;
   endfunction

endpackage

// File: rtl/cnt_prescale.sv
// Prescaler: one tick per PRESCALE enabled cycles.
// Cleared by reset and by a counter load.
module cnt_prescale
   import param_updown_cnt_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int PW = pw_of(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pcnt;

   assign tick = en & (pcnt == LAST);

   // Count enabled cycles, wrapping to zero on the tick.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pcnt <= '0;
      end else if (clr) begin
         pcnt <= '0;
      end else if (tick) begin
         pcnt <= '0;
      end else if (en) begin
         pcnt <= pcnt + 1'b1;
      end
   end

endmodule

// File: rtl/param_updown_cnt.sv
// Parametrised up/down modulo counter with load,
// prescaler, wrap/saturate mode, terminal count and sticky overflow.
module param_updown_cnt
   import param_updown_cnt_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MOD      = 16,
   parameter int WRAP     = 1,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             down,
   input  logic             load,
   input  logic [WIDTH-1:0] cnt_in,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             at_max,
   output logic             at_zero,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);

   if (MOD > 2 ** WIDTH || MOD < 2) begin : g_bad_mod
      $error("param_updown_cnt: MOD out of range");
   end

   logic             tick;
   logic             step;
   logic             bnd;
   logic [WIDTH-1:0] ld_val;
   logic [WIDTH-1:0] nxt;

   cnt_prescale #(
      .PRESCALE(PRESCALE)
   ) u_pre (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .clr  (load),
      .tick (tick)
   );

   assign at_max  = (q == MAXV);
   assign at_zero = (q == '0);
   assign step    = tick & ~load;
   assign bnd     = step & (down ? at_zero : at_max);

   // Out-of-range load values clamp to the top of the range.
   always_comb begin
      ld_val = cnt_in;
      if ({1'b0, cnt_in} >= (WIDTH + 1)'(MOD)) begin
         ld_val = MAXV;
      end
   end

   // Next count for a step, wrapping or saturating at the ends.
   always_comb begin
      nxt = q;
      if (down) begin
         if (at_zero) nxt = (WRAP != 0) ? MAXV : '0;
         else         nxt = q - 1'b1;
      end else begin
         if (at_max)  nxt = (WRAP != 0) ? '0 : MAXV;
         else         nxt = q + 1'b1;
      end
   end

   // Count register, terminal-count pulse and sticky overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q   <= '0;
         tc  <= 1'b0;
         ovf <= 1'b0;
      end else begin
         tc  <= bnd;
         ovf <= bnd | (ovf & ~ovf_clr);
         if (load) begin
            q <= ld_val;
         end else if (step) begin
            q <= nxt;
         end
      end
   end

endmodule

// File: tb/tb_param_updown_cnt.sv
// Bench for param_updown_cnt: directed table, hand sequences
// and random stimulus against an arithmetic reference model.
module tb_param_updown_cnt;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       down = 1'b0;
   logic       load = 1'b0;
   logic [3:0] cnt_in = '0;
   logic       ovf_clr = 1'b0;

   logic [3:0] dq [3];
   logic       dtc [3];
   logic       dmax [3];
   logic       dzero [3];
   logic       dovf [3];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   param_updown_cnt #(.WIDTH(4), .MOD(10), .WRAP(1), .PRESCALE(1)) u0 (
      .clk(clk), .rst_n(rst_n), .en(en), .down(down), .load(load),
      .cnt_in(cnt_in), .ovf_clr(ovf_clr), .q(dq[0]), .tc(dtc[0]),
      .at_max(dmax[0]), .at_zero(dzero[0]), .ovf(dovf[0])
   );
   param_updown_cnt #(.WIDTH(4), .MOD(10), .WRAP(0), .PRESCALE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en), .down(down), .load(load),
      .cnt_in(cnt_in), .ovf_clr(ovf_clr), .q(dq[1]), .tc(dtc[1]),
      .at_max(dmax[1]), .at_zero(dzero[1]), .ovf(dovf[1])
   );
   param_updown_cnt #(.WIDTH(4), .MOD(10), .WRAP(1), .PRESCALE(3)) u2 (
      .clk(clk), .rst_n(rst_n), .en(en), .down(down), .load(load),
      .cnt_in(cnt_in), .ovf_clr(ovf_clr), .q(dq[2]), .tc(dtc[2]),
      .at_max(dmax[2]), .at_zero(dzero[2]), .ovf(dovf[2])
   );

   // Reference model: plain integer arithmetic on the counting rules.
   int modv [3] = '{10, 10, 10};
   int wrapv [3] = '{1, 0, 1};
   int prev [3] = '{1, 1, 3};
   int mq [3] = '{0, 0, 0};
   int mpc [3] = '{0, 0, 0};
   int mtc [3] = '{0, 0, 0};
   int movf [3] = '{0, 0, 0};

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         int b;
         b = 0;
         if (!rst_n) begin
            mq[i] = 0; mpc[i] = 0; mtc[i] = 0; movf[i] = 0;
         end else begin
            if (load) begin
               mq[i] = (int'(cnt_in) >= modv[i]) ? modv[i] - 1 : int'(cnt_in);
               mpc[i] = 0;
            end else if (en) begin
               if (mpc[i] + 1 < prev[i]) begin
                  mpc[i] = mpc[i] + 1;
               end else begin
                  mpc[i] = 0;
                  if (!down) begin
                     if (mq[i] == modv[i] - 1) begin
                        b = 1;
                        mq[i] = wrapv[i] ? 0 : modv[i] - 1;
                     end else mq[i] = mq[i] + 1;
                  end else begin
                     if (mq[i] == 0) begin
                        b = 1;
                        mq[i] = wrapv[i] ? modv[i] - 1 : 0;
                     end else mq[i] = mq[i] - 1;
                  end
               end
            end
            mtc[i] = b;
            movf[i] = (b != 0 || (movf[i] != 0 && !ovf_clr)) ? 1 : 0;
         end
      end
   end

   task automatic expect_eq(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_model();
      for (int i = 0; i < 3; i++) begin
         int got, exp;
         got = {dq[i], dtc[i], dovf[i], dmax[i], dzero[i]};
         exp = {mq[i][3:0], mtc[i][0], movf[i][0],
                mq[i] == modv[i] - 1, mq[i] == 0};
         if ($isunknown({dq[i], dtc[i], dovf[i], dmax[i], dzero[i]}))
            got = -1;
         expect_eq($sformatf("model_dut%0d {q,tc,ovf,max,zero}", i), got, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic e, input logic d,
                      input logic l, input logic [3:0] c, input logic oc);
      @(negedge clk);
      rst_n = r; en = e; down = d; load = l; cnt_in = c; ovf_clr = oc;
      @(posedge clk);
      #1;
      check_model();
   endtask

   typedef struct {
      logic       r, e, d, l;
      logic [3:0] c;
      logic       oc;
      int         eq, etc, eovf;
   } vec_t;

   function automatic vec_t mk(input logic r, e, d, l, input logic [3:0] c,
                               input logic oc, input int eq, etc, eovf);
      vec_t v;
      v.r = r; v.e = e; v.d = d; v.l = l; v.c = c; v.oc = oc;
      v.eq = eq; v.etc = etc; v.eovf = eovf;
      return v;
   endfunction

   vec_t vt [$];
   int   pre_q [11] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};
   logic pre_en [11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};

   initial begin
      // Wrap config, prescale 1: expectations for u0.
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int k = 1; k <= 9; k++) vt.push_back(mk(1, 1, 0, 0, 0, 0, k, 0, 0));
      vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 1));
      vt.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 1));
      vt.push_back(mk(1, 1, 0, 0, 0, 0, 2, 0, 1));
      vt.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1));
      vt.push_back(mk(1, 1, 1, 0, 0, 0, 9, 1, 1));
      vt.push_back(mk(1, 1, 1, 0, 0, 0, 8, 0, 1));
      vt.push_back(mk(1, 1, 0, 1, 13, 0, 9, 0, 1));
      vt.push_back(mk(1, 0, 0, 0, 0, 0, 9, 0, 1));
      vt.push_back(mk(1, 0, 0, 0, 0, 1, 9, 0, 0));
      vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 1));
      vt.push_back(mk(1, 0, 0, 1, 9, 0, 9, 0, 1));
      vt.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1, 1));
      vt.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
      for (int k = 1; k <= 3; k++) vt.push_back(mk(1, 1, 0, 0, 0, 0, k, 0, 0));
      vt.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
      vt.push_back(mk(1, 1, 1, 0, 0, 0, 9, 1, 1));
      vt.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));

      foreach (vt[k]) begin
         cyc(vt[k].r, vt[k].e, vt[k].d, vt[k].l, vt[k].c, vt[k].oc);
         expect_eq($sformatf("vec%0d q", k), int'(dq[0]), vt[k].eq);
         expect_eq($sformatf("vec%0d tc", k), int'(dtc[0]), vt[k].etc);
         expect_eq($sformatf("vec%0d ovf", k), int'(dovf[0]), vt[k].eovf);
      end

      // Saturate config: held ticks at the top keep re-pulsing tc.
      cyc(1, 0, 0, 1, 8, 0);
      expect_eq("sat load8 q", int'(dq[1]), 8);
      cyc(1, 1, 0, 0, 0, 0);
      expect_eq("sat up1 q", int'(dq[1]), 9);
      expect_eq("sat up1 tc", int'(dtc[1]), 0);
      cyc(1, 1, 0, 0, 0, 0);
      expect_eq("sat up2 q", int'(dq[1]), 9);
      expect_eq("sat up2 tc", int'(dtc[1]), 1);
      cyc(1, 1, 0, 0, 0, 0);
      expect_eq("sat up3 q", int'(dq[1]), 9);
      expect_eq("sat up3 tc", int'(dtc[1]), 1);
      expect_eq("sat ovf", int'(dovf[1]), 1);
      cyc(1, 1, 1, 0, 0, 0);
      expect_eq("sat down q", int'(dq[1]), 8);
      expect_eq("sat down tc", int'(dtc[1]), 0);

      // Prescale 3 with an en gap in the middle.
      cyc(0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 11; k++) begin
         cyc(1, pre_en[k], 0, 0, 0, 0);
         expect_eq($sformatf("pre cyc%0d q", k), int'(dq[2]), pre_q[k]);
      end

      // Random traffic checked against the model every cycle.
      for (int k = 0; k < 3000; k++) begin
         cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7),
             1'($urandom), ($urandom_range(0, 9) == 0),
             4'($urandom), ($urandom_range(0, 9) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
